button_event_controller: RTL and testbench

- Conditions N raw, asynchronous push-button inputs from the FPGA board into the Clk domain.
- Per button: synchronize, debounce, detect the press edge.
- Presses are queued as sticky pending requests and delivered one at a time, round-robin, over a valid/ready event port to downstream control logic (menu/FSM consumers).
- Single point of entry for all user buttons into clocked logic.

---
 rtl/button_event_controller_pkg.sv | 13 +
 rtl/button_event_controller_debounce_channel.sv | 55 +++++
 rtl/button_event_controller.sv | 104 ++++++++++
 tb/tb_button_event_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_controller_pkg.sv
// Shared defaults and helpers for the button event controller.
// Debounce defaults assume a 100 MHz board clock.
package button_event_controller_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int SYNC_STAGES_DEFAULT     = 3;

  // Event index width; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_controller_debounce_channel.sv
// One button channel: synchronizer chain, debounce counter, accepted level and press strobe.
// Rise is combinational and fires during the cycle whose closing edge raises Stable.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 3
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Raw,
  output logic Stable,
  output logic Rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   stable_p2;
  logic                   differ;
  logic                   done;

  // Stage 0: synchronizer chain
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], Raw};
    end
  end

  assign s_p1   = sync_p0[SYNC_STAGES-1];
  assign differ = (s_p1 != stable_p2);
  assign done   = differ && (cnt_p1 == CNT_LAST);

  // Stage 1: debounce counter and accepted level
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_p1    <= '0;
      stable_p2 <= 1'b0;
    end else if (!differ) begin
      cnt_p1    <= '0;
    end else if (done) begin
      cnt_p1    <= '0;
      stable_p2 <= ~stable_p2;
    end else begin
      cnt_p1    <= cnt_p1 + 1'b1;
    end
  end

  assign Stable = stable_p2;
  assign Rise   = done && !stable_p2;

endmodule

// File: rtl/button_event_controller.sv
// Debounced push-button front end: per-channel conditioning, sticky press requests
// and a round-robin valid/ready event port.
module button_event_controller
  import button_event_controller_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [N-1:0]          InButtons,
  output logic [N-1:0]          Stable,
  output logic                  EventValid,
  output logic [idx_w(N)-1:0]   EventId,
  input  logic                  EventReady,
  output logic [N-1:0]          Overrun
);

  localparam int IDX_W = idx_w(N);

  logic [N-1:0]     rise;
  logic [N-1:0]     pend_p1;
  logic [N-1:0]     ovr_p1;
  logic [N-1:0]     clr;
  logic [N-1:0]     req;
  logic [IDX_W-1:0] ptr_p1;
  logic             ev_vld_p2;
  logic [IDX_W-1:0] ev_id_p2;
  logic             accept;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_found;

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Raw    (InButtons[g]),
      .Stable (Stable[g]),
      .Rise   (rise[g])
    );
  end

  assign accept = ev_vld_p2 && EventReady;

  // The accepted channel is hidden from this edge's search; a fresh press on it
  // re-enters pending and is granted on a later edge.
  always_comb begin
    clr = '0;
    if (accept) clr[ev_id_p2] = 1'b1;
    req       = pend_p1 & ~clr;
    base      = accept ? ev_id_p2 : ptr_p1;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(base) + k) % N);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Stage 1: pending requests and overrun flags
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_p1 <= '0;
      ovr_p1  <= '0;
    end else begin
      pend_p1 <= req | rise;
      ovr_p1  <= ovr_p1 | (rise & pend_p1 & ~clr);
    end
  end

  // Stage 2: registered grant and round-robin pointer
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ev_vld_p2 <= 1'b0;
      ev_id_p2  <= '0;
      ptr_p1    <= IDX_W'(N - 1);
    end else begin
      if (accept) ptr_p1 <= ev_id_p2;
      if (!ev_vld_p2 || accept) begin
        if (gnt_found) begin
          ev_vld_p2 <= 1'b1;
          ev_id_p2  <= gnt_idx;
        end else begin
          ev_vld_p2 <= 1'b0;
        end
      end
    end
  end

  assign EventValid = ev_vld_p2;
  assign EventId    = ev_id_p2;
  assign Overrun    = ovr_p1;

endmodule

// File: tb/tb_button_event_controller.sv
// Directed bench for button_event_controller with N=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=3.
// A press applied just after an edge raises Stable 7 edges later and EventValid on the 8th.
module tb_button_event_controller;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] InButtons;
  logic [3:0] Stable;
  logic       EventValid;
  logic [1:0] EventId;
  logic       EventReady;
  logic [3:0] Overrun;

  int passed = 0;
  int total  = 0;

  button_event_controller #(
    .N               (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (3)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .InButtons  (InButtons),
    .Stable     (Stable),
    .EventValid (EventValid),
    .EventId    (EventId),
    .EventReady (EventReady),
    .Overrun    (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; InButtons = 4'b0000; EventReady = 1'b0;
    #1;
    total++; if (Stable !== 4'b0000) $display("FAIL rst_stable: got %b want 0000", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", EventValid); else passed++;
    total++; if (EventId !== 2'd0) $display("FAIL rst_id: got %0d want 0", EventId); else passed++;
    total++; if (Overrun !== 4'b0000) $display("FAIL rst_overrun: got %b want 0000", Overrun); else passed++;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    InButtons = 4'b0001;
    tick(6);
    total++; if (Stable !== 4'b0000) $display("FAIL clean_stable_early: got %b want 0000", Stable); else passed++;
    tick(1);
    total++; if (Stable !== 4'b0001) $display("FAIL clean_stable_edge7: got %b want 0001", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL clean_valid_edge7: got %b want 0", EventValid); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b100) $display("FAIL clean_event_edge8: got v=%b id=%0d want v=1 id=0", EventValid, EventId); else passed++;
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    total++; if (EventValid !== 1'b0) $display("FAIL clean_valid_after_accept: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
    total++; if (Stable !== 4'b0000) $display("FAIL clean_release_stable: got %b want 0000", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL clean_release_noevent: got %b want 0", EventValid); else passed++;
  endtask

  task automatic test_glitch();
    InButtons = 4'b0010;
    tick(3);
    InButtons = 4'b0000;
    tick(12);
    total++; if (Stable !== 4'b0000) $display("FAIL glitch_stable: got %b want 0000", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL glitch_noevent: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0010;
    tick(1);
    InButtons = 4'b0000;
    tick(1);
    InButtons = 4'b0010;
    tick(6);
    total++; if (Stable !== 4'b0000) $display("FAIL bounce_stable_early: got %b want 0000", Stable); else passed++;
    tick(1);
    total++; if (Stable !== 4'b0010) $display("FAIL bounce_stable_edge7: got %b want 0010", Stable); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b101) $display("FAIL bounce_event: got v=%b id=%0d want v=1 id=1", EventValid, EventId); else passed++;
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    total++; if (EventValid !== 1'b0) $display("FAIL bounce_accept: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
  endtask

  task automatic test_round_robin();
    test_reset();
    EventReady = 1'b1;
    InButtons  = 4'b1101;
    tick(7);
    total++; if (Stable !== 4'b1101) $display("FAIL rr_stable: got %b want 1101", Stable); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b100) $display("FAIL rr_first: got v=%b id=%0d want v=1 id=0", EventValid, EventId); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b110) $display("FAIL rr_second: got v=%b id=%0d want v=1 id=2", EventValid, EventId); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b111) $display("FAIL rr_third: got v=%b id=%0d want v=1 id=3", EventValid, EventId); else passed++;
    tick(1);
    total++; if (EventValid !== 1'b0) $display("FAIL rr_drained: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
    InButtons = 4'b0101;
    tick(8);
    total++; if ({EventValid, EventId} !== 3'b100) $display("FAIL rr_pair_first: got v=%b id=%0d want v=1 id=0", EventValid, EventId); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b110) $display("FAIL rr_pair_second: got v=%b id=%0d want v=1 id=2", EventValid, EventId); else passed++;
    tick(1);
    total++; if (EventValid !== 1'b0) $display("FAIL rr_pair_drained: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
    EventReady = 1'b0;
  endtask

  task automatic test_backpressure();
    InButtons = 4'b0010;
    tick(8);
    total++; if ({EventValid, EventId} !== 3'b101) $display("FAIL bp_event: got v=%b id=%0d want v=1 id=1", EventValid, EventId); else passed++;
    InButtons = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      total++;
      if ({EventValid, EventId} !== 3'b101)
        $display("FAIL bp_hold_%0d: got v=%b id=%0d want v=1 id=1", i, EventValid, EventId);
      else passed++;
      if (i == 7) InButtons = 4'b0010;
    end
    total++; if (Overrun !== 4'b0010) $display("FAIL bp_overrun: got %b want 0010", Overrun); else passed++;
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    total++; if (EventValid !== 1'b0) $display("FAIL bp_accept: got %b want 0", EventValid); else passed++;
    tick(3);
    total++; if (EventValid !== 1'b0) $display("FAIL bp_single_event: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
  endtask

  task automatic test_reset_mid();
    InButtons = 4'b1000;
    tick(8);
    total++; if ({EventValid, EventId} !== 3'b111) $display("FAIL rm_event: got v=%b id=%0d want v=1 id=3", EventValid, EventId); else passed++;
    InButtons = 4'b1001;
    tick(5);
    #3;
    Rst_n = 1'b0;
    #1;
    total++; if (Stable !== 4'b0000) $display("FAIL rm_stable: got %b want 0000", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL rm_valid: got %b want 0", EventValid); else passed++;
    total++; if (EventId !== 2'd0) $display("FAIL rm_id: got %0d want 0", EventId); else passed++;
    total++; if (Overrun !== 4'b0000) $display("FAIL rm_overrun: got %b want 0000", Overrun); else passed++;
    InButtons = 4'b0000;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    tick(12);
    total++; if ({EventValid, Stable} !== 5'b00000) $display("FAIL rm_no_event: got v=%b stable=%b want v=0 stable=0000", EventValid, Stable); else passed++;
    InButtons = 4'b0001;
    tick(8);
    total++; if ({EventValid, EventId} !== 3'b100) $display("FAIL rm_repress: got v=%b id=%0d want v=1 id=0", EventValid, EventId); else passed++;
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    InButtons  = 4'b0000;
    tick(12);
  endtask

  task automatic test_collision();
    InButtons = 4'b0100;
    tick(8);
    total++; if ({EventValid, EventId} !== 3'b110) $display("FAIL col_event: got v=%b id=%0d want v=1 id=2", EventValid, EventId); else passed++;
    InButtons = 4'b0000;
    tick(7);
    total++; if (Stable !== 4'b0000) $display("FAIL col_released: got %b want 0000", Stable); else passed++;
    InButtons = 4'b0100;
    tick(6);
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    total++; if (Stable !== 4'b0100) $display("FAIL col_stable: got %b want 0100", Stable); else passed++;
    total++; if (EventValid !== 1'b0) $display("FAIL col_valid_gap: got %b want 0", EventValid); else passed++;
    total++; if (Overrun !== 4'b0000) $display("FAIL col_overrun: got %b want 0000", Overrun); else passed++;
    tick(1);
    total++; if ({EventValid, EventId} !== 3'b110) $display("FAIL col_reissue: got v=%b id=%0d want v=1 id=2", EventValid, EventId); else passed++;
    EventReady = 1'b1;
    tick(1);
    EventReady = 1'b0;
    total++; if (EventValid !== 1'b0) $display("FAIL col_final_accept: got %b want 0", EventValid); else passed++;
    InButtons = 4'b0000;
    tick(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_collision();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
